// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - shared types and constants for the stepper sequencer
package stepper_pkg;

  localparam int IDX_W = 3;

  // Half-step coil table {f3,f2,f1,f0}; entry 0 sits in the low nibble.
  localparam logic [31:0] HALF_TABLE = {
    4'b0001, 4'b1001, 4'b1000, 4'b1100,
    4'b0100, 4'b0110, 4'b0010, 4'b0011
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } step_state_e;

  function automatic logic [3:0] phase_of(input logic [IDX_W-1:0] idx);
    return HALF_TABLE[{2'b00, idx} * 5'd4 +: 4];
  endfunction

endpackage

// File: rtl/stepper_seq_if.sv
// rtl/stepper_seq_if.sv - control/status bundle between controller and sequencer
interface stepper_seq_if #(
  parameter int PER_W = 16,
  parameter int CNT_W = 16,
  parameter int POS_W = 24
) ();
  logic                    enable;
  logic                    dir;
  logic                    half_step;
  logic                    hold;
  logic [PER_W-1:0]        period;
  logic                    move_start;
  logic [CNT_W-1:0]        move_steps;
  logic                    busy;
  logic                    done;
  logic signed [POS_W-1:0] position;
  logic [3:0]              phase;

  modport master (
    output enable, dir, half_step, hold, period, move_start, move_steps,
    input  busy, done, position, phase
  );

  modport slave (
    input  enable, dir, half_step, hold, period, move_start, move_steps,
    output busy, done, position, phase
  );
endinterface

// File: rtl/stepper_rate_gen.sv
// rtl/stepper_rate_gen.sv - clocks-per-step counter producing a step tick
module stepper_rate_gen #(
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic [PER_W-1:0] period_i,
  output logic             tick_o
);

  logic [PER_W-1:0] count_q;

  // period_i is never 0 here; the sequencer substitutes 1 when latching.
  assign tick_o = run_i && (count_q == period_i - PER_W'(1));

  // Count while running, wrap on tick, hold at zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (!run_i || tick_o) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + PER_W'(1);
    end
  end

endmodule

// File: rtl/stepper_seq.sv
// rtl/stepper_seq.sv - counted-move stepper sequencer with full/half-step drive
module stepper_seq
  import stepper_pkg::*;
#(
  parameter int PER_W = 16,
  parameter int CNT_W = 16,
  parameter int POS_W = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  stepper_seq_if.slave  bus
);

  step_state_e             state_q;
  logic [IDX_W-1:0]        index_q;
  logic signed [POS_W-1:0] position_q;
  logic [CNT_W-1:0]        remaining_q;
  logic                    busy_q;
  logic                    done_q;
  logic [3:0]              phase_q;
  logic                    dir_q;
  logic                    half_q;
  logic [PER_W-1:0]        period_q;

  logic                    tick;
  logic                    step_now;
  logic [IDX_W-1:0]        idx_amt;
  logic [IDX_W-1:0]        index_d;
  logic signed [POS_W-1:0] pos_amt;
  logic signed [POS_W-1:0] position_d;

  stepper_rate_gen #(.PER_W(PER_W)) u_rate (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_i    (state_q == ST_RUN),
    .period_i (period_q),
    .tick_o   (tick)
  );

  // Next index/position for a step; an abort takes priority over a tick.
  always_comb begin
    step_now   = (state_q == ST_RUN) && bus.enable && tick;
    idx_amt    = half_q ? IDX_W'(1) : IDX_W'(2);
    pos_amt    = half_q ? POS_W'(1) : POS_W'(2);
    index_d    = index_q;
    position_d = position_q;
    if (step_now) begin
      index_d    = dir_q ? index_q + idx_amt : index_q - idx_amt;
      position_d = dir_q ? position_q + pos_amt : position_q - pos_amt;
    end
  end

  // Move FSM with registered busy/done/phase; phase tracks index_d so the
  // coil pattern changes in the same cycle the index register does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      index_q     <= '0;
      position_q  <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      phase_q     <= 4'b0000;
      dir_q       <= 1'b0;
      half_q      <= 1'b0;
      period_q    <= PER_W'(1);
    end else begin
      done_q  <= 1'b0;
      phase_q <= (bus.enable && (busy_q || bus.hold)) ? phase_of(index_d) : 4'b0000;
      case (state_q)
        ST_IDLE: begin
          if (bus.enable && bus.move_start) begin
            dir_q    <= bus.dir;
            half_q   <= bus.half_step;
            period_q <= (bus.period == '0) ? PER_W'(1) : bus.period;
            if (bus.move_steps != '0) begin
              remaining_q <= bus.move_steps;
              busy_q      <= 1'b1;
              state_q     <= ST_RUN;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_FINISH;
            end
          end
        end
        ST_RUN: begin
          if (!bus.enable) begin
            remaining_q <= '0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (step_now) begin
            index_q     <= index_d;
            position_q  <= position_d;
            remaining_q <= remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_FINISH;
            end
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.position = position_q;
  assign bus.phase    = phase_q;

endmodule

// File: tb/tb_stepper_seq.sv
// tb/tb_stepper_seq.sv - directed self-checking bench for stepper_seq
module tb_stepper_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  stepper_seq_if #(.PER_W(16), .CNT_W(16), .POS_W(24)) bus ();

  stepper_seq #(.PER_W(16), .CNT_W(16), .POS_W(24)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pos32();
    return {{8{bus.position[23]}}, bus.position};
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    next();
    rst_n = 1'b1;
    next();
  endtask

  // Pulses move_start for one cycle; returns 1 ns into cycle T+1.
  task automatic start(input logic d, input logic hs, input logic [15:0] per,
                       input logic [15:0] steps);
    bus.dir        = d;
    bus.half_step  = hs;
    bus.period     = per;
    bus.move_steps = steps;
    bus.move_start = 1'b1;
    next();
    bus.move_start = 1'b0;
  endtask

  initial begin
    bus.enable     = 1'b1;
    bus.dir        = 1'b0;
    bus.half_step  = 1'b0;
    bus.hold       = 1'b0;
    bus.period     = 16'd1;
    bus.move_start = 1'b0;
    bus.move_steps = 16'd0;

    // Reset and idle
    do_reset();
    check("rst_phase", {28'd0, bus.phase}, 32'h0);
    check("rst_pos", pos32(), 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);

    // Full step forward, period 4, 4 steps
    start(1'b1, 1'b0, 16'd4, 16'd4);
    check("fs_busy_t1", {31'd0, bus.busy}, 32'd1);
    repeat (3) next();
    check("fs_pos_t4", pos32(), 32'd0);
    next();
    check("fs_ph_t5", {28'd0, bus.phase}, 32'h6);
    check("fs_pos_t5", pos32(), 32'd2);
    repeat (4) next();
    check("fs_ph_t9", {28'd0, bus.phase}, 32'hC);
    repeat (4) next();
    check("fs_ph_t13", {28'd0, bus.phase}, 32'h9);
    check("fs_done_t13", {31'd0, bus.done}, 32'd0);
    repeat (4) next();
    check("fs_ph_t17", {28'd0, bus.phase}, 32'h3);
    check("fs_done_t17", {31'd0, bus.done}, 32'd1);
    check("fs_busy_t17", {31'd0, bus.busy}, 32'd0);
    check("fs_pos_t17", pos32(), 32'd8);
    next();
    check("fs_done_t18", {31'd0, bus.done}, 32'd0);
    check("fs_ph_t18", {28'd0, bus.phase}, 32'h0);

    // Half step reverse, period 1, 3 steps, hold on
    do_reset();
    bus.hold = 1'b1;
    start(1'b0, 1'b1, 16'd1, 16'd3);
    next();
    check("hs_ph_1", {28'd0, bus.phase}, 32'h1);
    next();
    check("hs_ph_2", {28'd0, bus.phase}, 32'h9);
    next();
    check("hs_ph_3", {28'd0, bus.phase}, 32'h8);
    check("hs_done", {31'd0, bus.done}, 32'd1);
    check("hs_pos", pos32(), 32'hFFFF_FFFD);
    next();
    check("hs_hold_ph", {28'd0, bus.phase}, 32'h8);
    check("hs_hold_busy", {31'd0, bus.busy}, 32'd0);

    // Zero-step move
    start(1'b1, 1'b0, 16'd5, 16'd0);
    check("z_done", {31'd0, bus.done}, 32'd1);
    check("z_busy1", {31'd0, bus.busy}, 32'd0);
    next();
    check("z_done_off", {31'd0, bus.done}, 32'd0);
    check("z_busy2", {31'd0, bus.busy}, 32'd0);
    check("z_phase", {28'd0, bus.phase}, 32'h8);
    check("z_pos", pos32(), 32'hFFFF_FFFD);

    // Abort by enable after 2 of 10 full steps, then resume
    do_reset();
    bus.hold = 1'b0;
    start(1'b1, 1'b0, 16'd3, 16'd10);
    repeat (3) next();
    check("ab_ph_1", {28'd0, bus.phase}, 32'h6);
    repeat (3) next();
    check("ab_ph_2", {28'd0, bus.phase}, 32'hC);
    bus.enable = 1'b0;
    next();
    check("ab_phase", {28'd0, bus.phase}, 32'h0);
    check("ab_busy", {31'd0, bus.busy}, 32'd0);
    check("ab_done", {31'd0, bus.done}, 32'd0);
    check("ab_pos", pos32(), 32'd4);
    repeat (3) next();
    check("ab_pos_stay", pos32(), 32'd4);
    check("ab_done_never", {31'd0, bus.done}, 32'd0);
    bus.enable = 1'b1;
    start(1'b1, 1'b0, 16'd1, 16'd1);
    next();
    check("res_phase", {28'd0, bus.phase}, 32'h9);
    check("res_pos", pos32(), 32'd6);
    check("res_done", {31'd0, bus.done}, 32'd1);

    // Period 0 treated as 1; start while busy ignored
    next();
    start(1'b1, 1'b0, 16'd0, 16'd2);
    check("p0_busy", {31'd0, bus.busy}, 32'd1);
    bus.move_steps = 16'd5;
    bus.move_start = 1'b1;
    next();
    bus.move_start = 1'b0;
    check("p0_ph_1", {28'd0, bus.phase}, 32'h3);
    check("p0_pos_1", pos32(), 32'd8);
    next();
    check("p0_ph_2", {28'd0, bus.phase}, 32'h6);
    check("p0_pos_2", pos32(), 32'd10);
    check("p0_done", {31'd0, bus.done}, 32'd1);
    repeat (4) next();
    check("p0_pos_end", pos32(), 32'd10);
    check("p0_busy_end", {31'd0, bus.busy}, 32'd0);

    // Reset mid-move
    start(1'b0, 1'b1, 16'd2, 16'd8);
    repeat (3) next();
    do_reset();
    check("mr_pos", pos32(), 32'd0);
    check("mr_busy", {31'd0, bus.busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
